output_port_arbiter: RTL and testbench

Round-robin arbiter for one router output port, producing the one-hot `grant` consumed by that port's output controller. It shares the output between the five input sources (PE, S, N, E, W) per virtual channel. Arbitration alternates between the even VC (0) and odd VC (1) under the global `polarity` signal. It keeps an independent fairness pointer per VC and only issues a grant when the selected VC's output buffer is empty.

---
 rtl/router_pkg.sv | 31 +++
 rtl/output_port_arbiter_rr_pick.sv | 47 ++++
 rtl/output_port_arbiter.sv | 117 +++++++++++
 tb/tb_output_port_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared router constants and types: port indices, virtual
//               channel identifiers and the request/grant vector type.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

  localparam int NUM_PORTS = 5;

  // Requester index within a request/grant vector
  localparam int P_PE = 0;
  localparam int P_S  = 1;
  localparam int P_N  = 2;
  localparam int P_E  = 3;
  localparam int P_W  = 4;

  // Virtual channel identifiers, served on alternating polarity
  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  typedef logic [NUM_PORTS-1:0] port_vec_t;

  // Out-of-range pointer values are folded back onto the highest-priority port
  function automatic logic [2:0] ptr_norm(input logic [2:0] ptr);
    return (ptr >= 3'(NUM_PORTS)) ? 3'd0 : ptr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/output_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority encoder. Returns the first set
//               request at or above the pointer, wrapping past the top port,
//               as a one-hot pick plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import router_pkg::*;
(
  input  port_vec_t  req,
  input  logic [2:0] ptr,
  output port_vec_t  pick,
  output logic [2:0] idx
);

  logic [2:0] w_ptr_n;
  logic [3:0] w_cand_wide;
  logic [2:0] w_cand;
  logic       w_found;

  assign w_ptr_n = ptr_norm(ptr);

  // Scan upward from the pointer, keeping only the first hit so pick stays one-hot
  always_comb begin
    pick        = '0;
    idx         = 3'd0;
    w_found     = 1'b0;
    w_cand_wide = 4'd0;
    w_cand      = 3'd0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_cand_wide = {1'b0, w_ptr_n} + 4'(k);
      if (w_cand_wide >= 4'(NUM_PORTS)) begin
        w_cand_wide = w_cand_wide - 4'(NUM_PORTS);
      end
      w_cand = w_cand_wide[2:0];
      if (!w_found && req[w_cand]) begin
        w_found      = 1'b1;
        pick[w_cand] = 1'b1;
        idx          = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : output_port_arbiter
// Description : Round-robin arbiter for one router output port. Serves VC0 or
//               VC1 according to polarity, keeps a fairness pointer per VC and
//               grants only into an empty output buffer. Registered one-hot
//               grant with one cycle of latency.
//               Optional grant statistics counters: define OPARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module output_port_arbiter
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 polarity,
  input  logic [NUM_PORTS-1:0] req_vc0,
  input  logic [NUM_PORTS-1:0] req_vc1,
  input  logic                 empty_vc0,
  input  logic                 empty_vc1,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 grant_vc,
  output logic                 grant_valid,
  output logic [CNT_W-1:0]     gcnt_vc0,
  output logic [CNT_W-1:0]     gcnt_vc1
);

  localparam logic [2:0] c_last_idx = 3'(NUM_PORTS - 1);

  logic [2:0] r_ptr_vc0;
  logic [2:0] r_ptr_vc1;
  port_vec_t  r_grant;
  logic       r_grant_vc;
  logic       r_grant_valid;

  port_vec_t  w_req;
  logic       w_empty;
  logic [2:0] w_ptr;
  logic       w_elig;
  port_vec_t  w_pick;
  logic [2:0] w_idx;
  logic [2:0] w_ptr_next;

  // Steer the active VC's request, buffer state and pointer into the one picker
  assign w_req   = polarity ? port_vec_t'(req_vc1) : port_vec_t'(req_vc0);
  assign w_empty = polarity ? empty_vc1 : empty_vc0;
  assign w_ptr   = polarity ? r_ptr_vc1 : r_ptr_vc0;
  assign w_elig  = w_empty && (|w_req);

  rr_pick u_rr_pick (
    .req  (w_req),
    .ptr  (w_ptr),
    .pick (w_pick),
    .idx  (w_idx)
  );

  // Winner's successor becomes the new top priority, wrapping past the last port
  assign w_ptr_next = (w_idx >= c_last_idx) ? 3'd0 : (w_idx + 3'd1);

  // Grant register and per-VC fairness pointers; only the served VC's pointer moves
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant       <= '0;
      r_grant_vc    <= VC_EVEN;
      r_grant_valid <= 1'b0;
      r_ptr_vc0     <= 3'd0;
      r_ptr_vc1     <= 3'd0;
    end else begin
      r_grant_valid <= w_elig;
      if (w_elig) begin
        r_grant    <= w_pick;
        r_grant_vc <= polarity;
        if (polarity == VC_ODD) begin
          r_ptr_vc1 <= w_ptr_next;
        end else begin
          r_ptr_vc0 <= w_ptr_next;
        end
      end else begin
        r_grant <= '0;
      end
    end
  end

  assign grant       = r_grant;
  assign grant_vc    = r_grant_vc;
  assign grant_valid = r_grant_valid;

`ifdef OPARB_STATS_EN
  logic [CNT_W-1:0] r_gcnt_vc0;
  logic [CNT_W-1:0] r_gcnt_vc1;

  // Saturating per-VC grant counters, counted at the same edge the grant registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gcnt_vc0 <= '0;
      r_gcnt_vc1 <= '0;
    end else if (w_elig) begin
      if (polarity == VC_ODD) begin
        if (r_gcnt_vc1 != {CNT_W{1'b1}}) r_gcnt_vc1 <= r_gcnt_vc1 + 1'b1;
      end else begin
        if (r_gcnt_vc0 != {CNT_W{1'b1}}) r_gcnt_vc0 <= r_gcnt_vc0 + 1'b1;
      end
    end
  end

  assign gcnt_vc0 = r_gcnt_vc0;
  assign gcnt_vc1 = r_gcnt_vc1;
`else
  assign gcnt_vc0 = '0;
  assign gcnt_vc1 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_port_arbiter
// Description : Directed self-checking bench for output_port_arbiter, with a
//               second instance using 2-bit statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_port_arbiter;

`ifdef OPARB_STATS_EN
  localparam bit c_stats = 1'b1;
`else
  localparam bit c_stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic [4:0]  req_vc0, req_vc1;
  logic        empty_vc0, empty_vc1;
  logic [4:0]  grant, grant2;
  logic        grant_vc, grant_vc2;
  logic        grant_valid, grant_valid2;
  logic [15:0] gcnt_vc0, gcnt_vc1;
  logic [1:0]  gcnt2_vc0, gcnt2_vc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_port_arbiter #(.NUM_PORTS(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .req_vc0(req_vc0), .req_vc1(req_vc1),
    .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
    .grant(grant), .grant_vc(grant_vc), .grant_valid(grant_valid),
    .gcnt_vc0(gcnt_vc0), .gcnt_vc1(gcnt_vc1)
  );

  output_port_arbiter #(.NUM_PORTS(5), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .polarity(polarity),
    .req_vc0(req_vc0), .req_vc1(req_vc1),
    .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
    .grant(grant2), .grant_vc(grant_vc2), .grant_valid(grant_valid2),
    .gcnt_vc0(gcnt2_vc0), .gcnt_vc1(gcnt2_vc1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic cyc(input logic p, input logic [4:0] r0, input logic [4:0] r1,
                     input logic e0, input logic e1);
    polarity  = p;
    req_vc0   = r0;
    req_vc1   = r1;
    empty_vc0 = e0;
    empty_vc1 = e1;
    @(posedge clk);
    #1;
  endtask

  // Check grant, grant_vc and grant_valid together
  task automatic gchk(input string tag, input logic [4:0] g, input logic vc);
    chk({tag, "_grant"}, {11'd0, grant}, {11'd0, g});
    chk({tag, "_vc"}, {15'd0, grant_vc}, {15'd0, vc});
    chk({tag, "_valid"}, {15'd0, grant_valid}, {15'd0, |g});
    chk({tag, "_grant2"}, {11'd0, grant2}, {11'd0, g});
  endtask

  initial begin
    reset = 1'b1;
    cyc(1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1);
    cyc(1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1);
    gchk("rst", 5'b00000, 1'b0);
    chk("rst_cnt0", gcnt_vc0, 16'd0);
    chk("rst_cnt1", gcnt_vc1, 16'd0);
    reset = 1'b0;

    // VC0 full request sweep, VC1 idle on odd turns
    cyc(1'b0, 5'b11111, 5'b00000, 1'b1, 1'b1); gchk("rr0_a", 5'b00001, 1'b0);
    cyc(1'b1, 5'b11111, 5'b00000, 1'b1, 1'b1); gchk("rr0_idle1", 5'b00000, 1'b0);
    cyc(1'b0, 5'b11111, 5'b00000, 1'b1, 1'b1); gchk("rr0_b", 5'b00010, 1'b0);
    cyc(1'b1, 5'b11111, 5'b00000, 1'b1, 1'b1);
    cyc(1'b0, 5'b11111, 5'b00000, 1'b1, 1'b1); gchk("rr0_c", 5'b00100, 1'b0);
    cyc(1'b1, 5'b11111, 5'b00000, 1'b1, 1'b1);
    cyc(1'b0, 5'b11111, 5'b00000, 1'b1, 1'b1); gchk("rr0_d", 5'b01000, 1'b0);
    cyc(1'b1, 5'b11111, 5'b00000, 1'b1, 1'b1);
    cyc(1'b0, 5'b11111, 5'b00000, 1'b1, 1'b1); gchk("rr0_e", 5'b10000, 1'b0);
    cyc(1'b1, 5'b11111, 5'b00000, 1'b1, 1'b1);
    cyc(1'b0, 5'b11111, 5'b00000, 1'b1, 1'b1); gchk("rr0_wrap", 5'b00001, 1'b0);
    // ptr_vc0 = 1, 6 VC0 grants so far

    // Full buffer blocks VC0 and leaves its pointer alone
    cyc(1'b1, 5'b00000, 5'b00000, 1'b1, 1'b1);
    cyc(1'b0, 5'b11111, 5'b00000, 1'b0, 1'b1); gchk("blk0", 5'b00000, 1'b0);
    cyc(1'b1, 5'b00000, 5'b00000, 1'b1, 1'b1);
    cyc(1'b0, 5'b00100, 5'b00000, 1'b1, 1'b1); gchk("grant_n", 5'b00100, 1'b0);
    // ptr_vc0 = 3 after granting N
    cyc(1'b1, 5'b00000, 5'b00000, 1'b1, 1'b1);
    cyc(1'b0, 5'b10100, 5'b00000, 1'b1, 1'b1); gchk("sparse_w", 5'b10000, 1'b0);
    cyc(1'b1, 5'b00000, 5'b00000, 1'b1, 1'b1);
    cyc(1'b0, 5'b10100, 5'b00000, 1'b1, 1'b1); gchk("sparse_wrap", 5'b00100, 1'b0);
    // ptr_vc0 = 3, 9 VC0 grants

    // VC1 gated by its buffer; grant_vc holds the last served VC
    cyc(1'b1, 5'b00000, 5'b00010, 1'b1, 1'b0); gchk("blk1", 5'b00000, 1'b0);
    cyc(1'b0, 5'b00000, 5'b00010, 1'b1, 1'b0); gchk("idle0", 5'b00000, 1'b0);
    cyc(1'b1, 5'b00000, 5'b00011, 1'b1, 1'b0); gchk("blk1_b", 5'b00000, 1'b0);
    cyc(1'b0, 5'b00000, 5'b00011, 1'b1, 1'b1);
    // ptr_vc1 still 0, so PE wins over S
    cyc(1'b1, 5'b00000, 5'b00011, 1'b1, 1'b1); gchk("unblk1", 5'b00001, 1'b1);
    cyc(1'b0, 5'b00000, 5'b00000, 1'b1, 1'b1);
    cyc(1'b1, 5'b00000, 5'b00010, 1'b1, 1'b1); gchk("unblk1_s", 5'b00010, 1'b1);
    // ptr_vc1 = 2, 2 VC1 grants

    // Interleaved full requests: each VC follows its own pointer
    cyc(1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1); gchk("il_0a", 5'b01000, 1'b0);
    cyc(1'b1, 5'b11111, 5'b11111, 1'b1, 1'b1); gchk("il_1a", 5'b00100, 1'b1);
    cyc(1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1); gchk("il_0b", 5'b10000, 1'b0);
    cyc(1'b1, 5'b11111, 5'b11111, 1'b1, 1'b1); gchk("il_1b", 5'b01000, 1'b1);
    // 11 VC0 grants, 4 VC1 grants; last grant went to E
    chk("cnt0", gcnt_vc0, c_stats ? 16'd11 : 16'd0);
    chk("cnt1", gcnt_vc1, c_stats ? 16'd4 : 16'd0);
    chk("cnt0_sat", {14'd0, gcnt2_vc0}, c_stats ? 16'd3 : 16'd0);
    chk("cnt1_sat", {14'd0, gcnt2_vc1}, c_stats ? 16'd3 : 16'd0);

    // Reset right after the grant to E
    reset = 1'b1;
    cyc(1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1); gchk("mid_rst", 5'b00000, 1'b0);
    chk("mid_rst_cnt0", gcnt_vc0, 16'd0);
    chk("mid_rst_cnt1", gcnt_vc1, 16'd0);
    reset = 1'b0;
    cyc(1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1); gchk("post_0a", 5'b00001, 1'b0);
    cyc(1'b1, 5'b11111, 5'b11111, 1'b1, 1'b1); gchk("post_1a", 5'b00001, 1'b1);
    cyc(1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1); gchk("post_0b", 5'b00010, 1'b0);
    // Polarity held high: the same VC keeps advancing while its buffer is empty
    cyc(1'b1, 5'b11111, 5'b11111, 1'b1, 1'b1); gchk("hold_1a", 5'b00010, 1'b1);
    cyc(1'b1, 5'b11111, 5'b11111, 1'b1, 1'b0); gchk("hold_1b", 5'b00000, 1'b1);
    cyc(1'b1, 5'b11111, 5'b11111, 1'b1, 1'b1); gchk("hold_1c", 5'b00100, 1'b1);
    chk("post_cnt0", gcnt_vc0, c_stats ? 16'd2 : 16'd0);
    chk("post_cnt1", gcnt_vc1, c_stats ? 16'd3 : 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
